// File: rtl/bsg_manycore_mmio_pkg.sv
// Shared encodings and response payload for the manycore MMIO responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Address map seen by the responder (word addresses):
//   0 .. els_p-1  register file words
//   els_p         print-stat port; only a store is legal here, and it has
//                 no effect on the registers
//   > els_p       unmapped; any access flags a protocol error
package bsg_manycore_mmio_pkg;

    typedef enum logic [1:0] {
        e_mmio_load     = 2'd0,
        e_mmio_store    = 2'd1,
        e_mmio_amoadd   = 2'd2,
        e_mmio_reserved = 2'd3
    } bsg_manycore_mmio_op_e;

    typedef enum logic {
        e_resp_credit = 1'b0,
        e_resp_int_wb = 1'b1
    } bsg_manycore_mmio_resp_type_e;

endpackage

// Response payload, parameterized by the instantiating module's widths.
`ifndef BSG_MANYCORE_MMIO_RESP_DECLARED
`define BSG_MANYCORE_MMIO_RESP_DECLARED
`define declare_BSG_MANYCORE_MMIO_RESP_S(data_width_mp, reg_id_width_mp, x_cord_width_mp, y_cord_width_mp) \
    typedef struct packed {                                              \
        bsg_manycore_mmio_pkg::bsg_manycore_mmio_resp_type_e resp_type;  \
        logic [data_width_mp-1:0]   data;                                \
        logic [reg_id_width_mp-1:0] reg_id;                              \
        logic [x_cord_width_mp-1:0] dest_x;                              \
        logic [y_cord_width_mp-1:0] dest_y;                              \
    } bsg_manycore_mmio_resp_s
`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO holding els_p entries of width_p bits.
// Latency: a write is visible at the head the cycle after it is enqueued.
// Backpressure: ready_o comes from the registered count only; a full FIFO
//               stays not-ready even in a cycle where it is being dequeued.
//
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   v_i/ready_o/data_i enqueue side (enqueue on v_i & ready_o)
//   v_o/data_o/yumi_i  dequeue side (yumi_i only while v_o is high)
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp = $clog2(els_p + 1);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] wr_ptr_r;
    logic [ptr_width_lp-1:0] rd_ptr_r;
    logic [cnt_width_lp-1:0] count_r;
    logic                    enq;
    logic                    deq;

    assign ready_o = (count_r != full_cnt_lp);
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rd_ptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (deq) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            if (enq & ~deq) begin
                count_r <= count_r + cnt_width_lp'(1);
            end else if (~enq & deq) begin
                count_r <= count_r - cnt_width_lp'(1);
            end
        end
    end

endmodule

// File: rtl/bsg_manycore_mmio_responder.sv
// Manycore-side responder: load / masked store / amoadd on a small register
//   file, with a print-stat port one word past the end of the registers.
// Latency: a request accepted in cycle N is answered at the earliest in N+1.
// Backpressure: req_ready_o drops while the response queue is full (no
//   same-cycle bypass); resp_* hold steady until resp_ready_i.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   req_*                 decoded request (valid/ready), op/addr/data/mask,
//                         requester coordinates and tag
//   resp_*                response (valid/ready): credit or int_wb with data,
//                         echoed tag and requester coordinates
//   stat_v_o, stat_tag_o  one-cycle print-stat pulse and its tag
//   error_o               sticky flag for unmapped or illegal requests
module bsg_manycore_mmio_responder
    import bsg_manycore_mmio_pkg::*;
#(
    parameter int x_cord_width_p = 7,
    parameter int y_cord_width_p = 7,
    parameter int addr_width_p   = 28,
    parameter int data_width_p   = 32,
    parameter int els_p          = 16,
    parameter int fifo_els_p     = 2,
    parameter int reg_id_width_p = 5
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      req_v_i,
    output logic                      req_ready_o,
    input  logic [1:0]                req_op_i,
    input  logic [addr_width_p-1:0]   req_addr_i,
    input  logic [data_width_p-1:0]   req_data_i,
    input  logic [data_width_p/8-1:0] req_mask_i,
    input  logic [x_cord_width_p-1:0] req_src_x_i,
    input  logic [y_cord_width_p-1:0] req_src_y_i,
    input  logic [reg_id_width_p-1:0] req_reg_id_i,

    output logic                      resp_v_o,
    input  logic                      resp_ready_i,
    output logic                      resp_type_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic [reg_id_width_p-1:0] resp_reg_id_o,
    output logic [x_cord_width_p-1:0] resp_dest_x_o,
    output logic [y_cord_width_p-1:0] resp_dest_y_o,

    output logic                      stat_v_o,
    output logic [data_width_p-1:0]   stat_tag_o,
    output logic                      error_o
);

    localparam int lg_els_lp     = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int mask_width_lp = data_width_p / 8;
    localparam logic [addr_width_p-1:0] stat_addr_lp = addr_width_p'(els_p);

    `declare_BSG_MANYCORE_MMIO_RESP_S(data_width_p, reg_id_width_p, x_cord_width_p, y_cord_width_p);

    bsg_manycore_mmio_resp_s resp_in;
    bsg_manycore_mmio_resp_s resp_out;

    logic [data_width_p-1:0] regs_r [els_p];
    logic                    stat_v_r;
    logic [data_width_p-1:0] stat_tag_r;
    logic                    error_r;

    bsg_manycore_mmio_op_e   op;
    logic                    in_range;
    logic [lg_els_lp-1:0]    idx;
    logic [data_width_p-1:0] rd_data;
    logic [data_width_p-1:0] wr_data;
    logic                    wr_en;
    logic                    stat_hit;
    logic                    bad_req;
    logic                    fifo_ready;
    logic                    fifo_v;
    logic                    accept;

    assign op       = bsg_manycore_mmio_op_e'(req_op_i);
    assign in_range = (req_addr_i < stat_addr_lp);
    assign idx      = req_addr_i[lg_els_lp-1:0];

    // Reset gates ready directly so nothing is accepted while the queue is
    // being cleared.
    assign req_ready_o = ~reset_i & fifo_ready;
    assign accept      = req_v_i & req_ready_o;

    // Decode and build the response in the accept cycle; the register write
    // commits on the same edge, so a back-to-back request to the same word
    // reads the updated value.
    always_comb begin
        rd_data        = regs_r[idx];
        wr_data        = rd_data;
        wr_en          = 1'b0;
        stat_hit       = 1'b0;
        bad_req        = 1'b0;
        resp_in        = '0;
        resp_in.reg_id = req_reg_id_i;
        resp_in.dest_x = req_src_x_i;
        resp_in.dest_y = req_src_y_i;

        if (op == e_mmio_reserved) begin
            resp_in.resp_type = e_resp_int_wb;
            bad_req           = 1'b1;
        end else if (in_range) begin
            case (op)
                e_mmio_load: begin
                    resp_in.resp_type = e_resp_int_wb;
                    resp_in.data      = rd_data;
                end
                e_mmio_store: begin
                    resp_in.resp_type = e_resp_credit;
                    wr_en             = 1'b1;
                    for (int b = 0; b < mask_width_lp; b++) begin
                        if (req_mask_i[b]) begin
                            wr_data[8*b +: 8] = req_data_i[8*b +: 8];
                        end
                    end
                end
                e_mmio_amoadd: begin
                    resp_in.resp_type = e_resp_int_wb;
                    resp_in.data      = rd_data;
                    wr_en             = 1'b1;
                    wr_data           = rd_data + req_data_i;
                end
                default: begin
                    resp_in.resp_type = e_resp_int_wb;
                end
            endcase
        end else if ((op == e_mmio_store) && (req_addr_i == stat_addr_lp)) begin
            resp_in.resp_type = e_resp_credit;
            stat_hit          = 1'b1;
        end else begin
            // Unmapped, or a non-store at the stat port: answer anyway so the
            // requester's credit accounting stays intact.
            resp_in.resp_type = (op == e_mmio_store) ? e_resp_credit : e_resp_int_wb;
            bad_req           = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                regs_r[i] <= '0;
            end
            stat_v_r   <= 1'b0;
            stat_tag_r <= '0;
            error_r    <= 1'b0;
        end else begin
            if (accept & wr_en) begin
                regs_r[idx] <= wr_data;
            end
            stat_v_r <= accept & stat_hit;
            if (accept & stat_hit) begin
                stat_tag_r <= req_data_i;
            end
            if (accept & bad_req) begin
                error_r <= 1'b1;
            end
        end
    end

    bsg_fifo_1r1w_small #(
        .width_p ($bits(bsg_manycore_mmio_resp_s)),
        .els_p   (fifo_els_p)
    ) resp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (accept),
        .ready_o (fifo_ready),
        .data_i  (resp_in),
        .v_o     (fifo_v),
        .data_o  (resp_out),
        .yumi_i  (fifo_v & resp_ready_i)
    );

    assign resp_v_o      = fifo_v;
    assign resp_type_o   = resp_out.resp_type;
    assign resp_data_o   = resp_out.data;
    assign resp_reg_id_o = resp_out.reg_id;
    assign resp_dest_x_o = resp_out.dest_x;
    assign resp_dest_y_o = resp_out.dest_y;

    assign stat_v_o   = stat_v_r;
    assign stat_tag_o = stat_tag_r;
    assign error_o    = error_r;

endmodule

// File: tb/tb_bsg_manycore_mmio_responder.sv
module tb_bsg_manycore_mmio_responder;

    localparam int XW = 7, YW = 7, AW = 28, DW = 32, ELS = 16, FIFO = 2, RW = 5;
    localparam int NV = 21;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          req_v_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = '0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_data_i = '0;
    logic [3:0]    req_mask_i = '0;
    logic [XW-1:0] req_src_x_i = '0;
    logic [YW-1:0] req_src_y_i = '0;
    logic [RW-1:0] req_reg_id_i = '0;
    logic          resp_v_o;
    logic          resp_ready_i = 1'b1;
    logic          resp_type_o;
    logic [DW-1:0] resp_data_o;
    logic [RW-1:0] resp_reg_id_o;
    logic [XW-1:0] resp_dest_x_o;
    logic [YW-1:0] resp_dest_y_o;
    logic          stat_v_o;
    logic [DW-1:0] stat_tag_o;
    logic          error_o;

    always #5 clk = ~clk;

    bsg_manycore_mmio_responder #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .addr_width_p(AW),
        .data_width_p(DW), .els_p(ELS), .fifo_els_p(FIFO), .reg_id_width_p(RW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
        .req_src_x_i(req_src_x_i), .req_src_y_i(req_src_y_i), .req_reg_id_i(req_reg_id_i),
        .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_type_o(resp_type_o),
        .resp_data_o(resp_data_o), .resp_reg_id_o(resp_reg_id_o),
        .resp_dest_x_o(resp_dest_x_o), .resp_dest_y_o(resp_dest_y_o),
        .stat_v_o(stat_v_o), .stat_tag_o(stat_tag_o), .error_o(error_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endtask

    // ---------------- reference model (checked every falling edge) ----------
    typedef struct {
        logic          typ;
        logic [DW-1:0] data;
        logic          chk_data;
        logic [RW-1:0] id;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } exp_t;

    exp_t          m_q[$];
    logic [DW-1:0] m_regs [ELS];
    logic          m_err = 1'b0;
    logic          m_stat_pend = 1'b0;
    logic [DW-1:0] m_stat_tag = '0;
    bit            mon_en = 1'b1;

    always @(negedge clk) begin : monitor
        exp_t e;
        int   a;
        if (mon_en) begin
            if (reset_i) begin
                chk("mdl_ready_in_reset", req_ready_o, 0);
                m_q.delete();
                m_err = 1'b0;
                m_stat_pend = 1'b0;
                for (int i = 0; i < ELS; i++) m_regs[i] = '0;
            end else begin
                chk("mdl_req_ready", req_ready_o, m_q.size() < FIFO);
                chk("mdl_resp_v", resp_v_o, m_q.size() != 0);
                chk("mdl_stat_v", stat_v_o, m_stat_pend);
                if (m_stat_pend) chk("mdl_stat_tag", stat_tag_o, m_stat_tag);
                chk("mdl_error", error_o, m_err);
                if (resp_v_o && m_q.size() != 0) begin
                    chk("mdl_resp_type", resp_type_o, m_q[0].typ);
                    if (m_q[0].chk_data) chk("mdl_resp_data", resp_data_o, m_q[0].data);
                    chk("mdl_resp_id", resp_reg_id_o, m_q[0].id);
                    chk("mdl_resp_x", resp_dest_x_o, m_q[0].x);
                    chk("mdl_resp_y", resp_dest_y_o, m_q[0].y);
                    if (resp_ready_i) void'(m_q.pop_front());
                end
                m_stat_pend = 1'b0;
                if (req_v_i && req_ready_o) begin
                    e.id = req_reg_id_i;
                    e.x = req_src_x_i;
                    e.y = req_src_y_i;
                    e.data = '0;
                    e.chk_data = 1'b0;
                    if (req_op_i == 2'd3) begin
                        e.typ = 1'b1;
                        e.chk_data = 1'b1;
                        m_err = 1'b1;
                    end else if (req_addr_i < ELS) begin
                        a = int'(req_addr_i);
                        e.chk_data = 1'b1;
                        if (req_op_i == 2'd0) begin
                            e.typ = 1'b1;
                            e.data = m_regs[a];
                        end else if (req_op_i == 2'd1) begin
                            e.typ = 1'b0;
                            for (int b = 0; b < 4; b++)
                                if (req_mask_i[b]) m_regs[a][8*b +: 8] = req_data_i[8*b +: 8];
                        end else begin
                            e.typ = 1'b1;
                            e.data = m_regs[a];
                            m_regs[a] = m_regs[a] + req_data_i;
                        end
                    end else if (req_addr_i == ELS && req_op_i == 2'd1) begin
                        e.typ = 1'b0;
                        m_stat_pend = 1'b1;
                        m_stat_tag = req_data_i;
                    end else begin
                        e.typ = (req_op_i == 2'd1) ? 1'b0 : 1'b1;
                        e.chk_data = e.typ;
                        m_err = 1'b1;
                    end
                    m_q.push_back(e);
                end
            end
        end
    end

    // ---------------- directed vectors -------------------------------------
    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    mask;
        logic          exp_type;
        logic [DW-1:0] exp_data;
        logic          chkd;
        logic          exp_stat;
        logic          exp_err;
    } vec_t;

    vec_t vecs [NV];

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [3:0] mask,
                         input logic [RW-1:0] id);
        int n;
        n = 0;
        req_op_i = op;
        req_addr_i = addr;
        req_data_i = data;
        req_mask_i = mask;
        req_reg_id_i = id;
        req_src_x_i = XW'(id + 3);
        req_src_y_i = YW'(id + 9);
        req_v_i = 1'b1;
        forever begin
            @(negedge clk);
            if (req_ready_o) break;
            n++;
            if (n > 50) begin
                note_timeout("accept_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        req_v_i = 1'b0;
    endtask

    initial begin
        //            op    addr    data          mask  type  exp_data      chkd stat err
        vecs[0]  = '{2'd1, 28'd3,  32'hA5A5A5A5, 4'hF, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{2'd0, 28'd3,  32'h0,        4'h0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{2'd1, 28'd5,  32'h12345678, 4'hF, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{2'd1, 28'd5,  32'h000000FF, 4'h1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{2'd0, 28'd5,  32'h0,        4'h0, 1'b1, 32'h123456FF, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{2'd1, 28'd7,  32'hFFFFFFFF, 4'hF, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{2'd2, 28'd7,  32'h00000001, 4'h0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{2'd0, 28'd7,  32'h0,        4'h0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'd1, 28'd16, 32'h0000BEEF, 4'hF, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2'd0, 28'd3,  32'h0,        4'h0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{2'd2, 28'd3,  32'h11111111, 4'h0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{2'd0, 28'd3,  32'h0,        4'h0, 1'b1, 32'hB6B6B6B6, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{2'd1, 28'd2,  32'hDEADBEEF, 4'hA, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{2'd0, 28'd2,  32'h0,        4'h0, 1'b1, 32'hDE00BE00, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{2'd0, 28'd21, 32'h0,        4'h0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{2'd1, 28'd16, 32'h00001234, 4'hF, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{2'd3, 28'd0,  32'h55555555, 4'hF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{2'd1, 28'd30, 32'h77777777, 4'hF, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{2'd0, 28'd16, 32'h0,        4'h0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{2'd1, 28'd3,  32'hFFFFFFFF, 4'h0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[20] = '{2'd0, 28'd3,  32'h0,        4'h0, 1'b1, 32'hB6B6B6B6, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp_v", resp_v_o, 0);
        chk("reset_stat_v", stat_v_o, 0);
        chk("reset_error", error_o, 0);
        chk("reset_req_ready", req_ready_o, 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", req_ready_o, 1);
        @(posedge clk);
        #1;

        // Table of single transactions, one in flight at a time
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask, RW'(i));
            @(negedge clk);
            chk($sformatf("tbl%0d_resp_v", i), resp_v_o, 1);
            chk($sformatf("tbl%0d_type", i), resp_type_o, vecs[i].exp_type);
            if (vecs[i].chkd) chk($sformatf("tbl%0d_data", i), resp_data_o, vecs[i].exp_data);
            chk($sformatf("tbl%0d_id", i), resp_reg_id_o, i);
            chk($sformatf("tbl%0d_stat", i), stat_v_o, vecs[i].exp_stat);
            if (vecs[i].exp_stat) chk($sformatf("tbl%0d_stat_tag", i), stat_tag_o, vecs[i].data);
            chk($sformatf("tbl%0d_error", i), error_o, vecs[i].exp_err);
            @(negedge clk);
            chk($sformatf("tbl%0d_stat_once", i), stat_v_o, 0);
            chk($sformatf("tbl%0d_drained", i), resp_v_o, 0);
            @(posedge clk);
            #1;
        end

        // Backpressure: two accepts fill the queue, third waits
        resp_ready_i = 1'b0;
        issue(2'd0, 28'd3, 32'h0, 4'h0, 5'd1);
        issue(2'd0, 28'd4, 32'h0, 4'h0, 5'd2);
        req_op_i = 2'd0;
        req_addr_i = 28'd5;
        req_reg_id_i = 5'd3;
        req_v_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_full_ready", req_ready_o, 0);
            chk("bp_head_hold", resp_reg_id_o, 1);
        end
        @(posedge clk);
        #1;
        resp_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_no_bypass", req_ready_o, 0);
        chk("bp_order1", resp_reg_id_o, 1);
        @(negedge clk);
        chk("bp_resume", req_ready_o, 1);
        chk("bp_order2", resp_reg_id_o, 2);
        @(posedge clk);
        #1;
        req_v_i = 1'b0;
        @(negedge clk);
        chk("bp_order3", resp_reg_id_o, 3);
        chk("bp_order3_v", resp_v_o, 1);
        @(negedge clk);
        chk("bp_drained", resp_v_o, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a drain
        resp_ready_i = 1'b0;
        issue(2'd0, 28'd5, 32'h0, 4'h0, 5'd7);
        issue(2'd0, 28'd6, 32'h0, 4'h0, 5'd8);
        resp_ready_i = 1'b1;
        @(negedge clk);
        chk("rst_drain_head", resp_reg_id_o, 7);
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid_drain_resp_v", resp_v_o, 0);
        chk("rst_mid_drain_error", error_o, 0);
        chk("rst_mid_drain_ready", req_ready_o, 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst_ready_again", req_ready_o, 1);
        @(posedge clk);
        #1;
        issue(2'd0, 28'd3, 32'h0, 4'h0, 5'd9);
        @(negedge clk);
        chk("rst_regs_cleared_type", resp_type_o, 1);
        chk("rst_regs_cleared_data", resp_data_o, 0);
        @(posedge clk);
        #1;

        // Randomized traffic, checked by the model
        for (int c = 0; c < 1500; c++) begin
            reset_i = ($urandom_range(0, 199) == 0);
            req_v_i = ($urandom_range(0, 3) != 0);
            resp_ready_i = ($urandom_range(0, 3) != 0);
            req_op_i = ($urandom_range(0, 29) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            req_addr_i = ($urandom_range(0, 24) == 0) ? AW'($urandom) : AW'($urandom_range(0, ELS));
            req_data_i = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            req_mask_i = 4'($urandom);
            req_reg_id_i = RW'($urandom);
            req_src_x_i = XW'($urandom);
            req_src_y_i = YW'($urandom);
            @(posedge clk);
            #1;
        end
        reset_i = 1'b0;
        req_v_i = 1'b0;
        resp_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_drained", resp_v_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_mmio_responder.md
# bsg_manycore_mmio_responder

Manycore-side responder for host-initiated remote requests: it is the far end of the host DPI endpoint's request/response protocol. It accepts decoded request packets (load, masked store, atomic add) targeting a small word-addressed register file, and returns load/atomic data or store credits to the requester. A store to a reserved address raises a print-stat event, the producer-side counterpart of the print-stat snoop. The block sits behind a manycore endpoint adapter inside simulation-only testbench tiles.

## Interface
- x_cord_width_p, 7: X coordinate width of the requester.
- y_cord_width_p, 7: Y coordinate width of the requester.
- addr_width_p, 28: EPA word-address width.
- data_width_p, 32: word width, a multiple of 8.
- els_p, 16: register-file depth in words, at least 2.
- fifo_els_p, 2: response-queue depth, at least 2.
- reg_id_width_p, 5: request tag width.
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_op_i  in  2  0=load, 1=store, 2=amoadd, 3=reserved.
- req_addr_i  in  addr_width_p  word address.
- req_data_i  in  data_width_p  store or amo operand.
- req_mask_i  in  data_width_p/8  store byte mask.
- req_src_x_i / req_src_y_i  in  x/y_cord_width_p  requester coordinates.
- req_reg_id_i  in  reg_id_width_p  tag, echoed in the response.
- resp_v_o  out  1  response valid.
- resp_ready_i  in  1  response ready.
- resp_type_o  out  1  0=credit, 1=int_wb.
- resp_data_o  out  data_width_p  returned data.
- resp_reg_id_o  out  reg_id_width_p  echoed tag.
- resp_dest_x_o / resp_dest_y_o  out  x/y_cord_width_p  requester coordinates.
- stat_v_o  out  1  single-cycle print-stat pulse.
- stat_tag_o  out  data_width_p  print-stat tag.
- error_o  out  1  sticky protocol-error flag.

## Operation
- **Accept.** A request is accepted on req_v_i & req_ready_o.
  - req_ready_o = ~reset_i & (queue count < fifo_els_p).
  - The count is registered. There is no bypass: when the queue is full and dequeuing, req_ready_o stays 0 that cycle.
- **Load, addr < els_p.** Response is int_wb with data = reg[addr].
- **Store, addr < els_p.** Each byte b with mask[b]=1 is written from data. Response is credit with data=0.
- **amoadd, addr < els_p.** Response is int_wb with the old value. reg[addr] ← old + data, modulo 2^data_width_p (wrap, no saturation).
- **Store, addr == els_p (stat port).** stat_v_o=1 and stat_tag_o=data in the cycle after acceptance. Registers are unchanged. Response is credit.
- **Load or amoadd at addr == els_p, any addr > els_p, or op 3.** Response is int_wb with data 0 for load, amoadd and op 3, or credit for a store. error_o is set and stays set until reset. No register is written.
- Responses leave in acceptance order. Every accepted request produces exactly one response.
- **Back-to-back requests to the same address.** The second request sees the first one's update, because the write commits in the accept cycle and the read in the next accept cycle reads the updated value.

## Timing
- **Reset values.** req_ready_o=0, resp_v_o=0, stat_v_o=0, error_o=0, all registers 0, queue empty. resp_* data outputs are don't-care while resp_v_o=0.
- req_ready_o=1 in the first cycle after reset deasserts.
- **Latency.** Accept in cycle N gives resp_v_o=1 in N+1 at the earliest.
- With resp_ready_i held high and fifo_els_p ≥ 2, the block sustains one request per cycle.
- Once resp_v_o is asserted, resp_v_o and all resp_* fields stay stable until resp_ready_i.
- **Reset mid-operation.** Queued responses and in-flight stat pulses are discarded. Registers return to 0.

## Structure
- Op and response-type encodings (`e_mmio_load`/`store`/`amoadd`, `e_resp_credit`/`int_wb`) go in the shared package `bsg_manycore_mmio_pkg`, with the stat-offset rule documented there.
- The response payload is a packed struct in that package, parameterized through a `declare_` macro.
- Sub-module: bsg_fifo_1r1w_small (depth fifo_els_p) holds the response queue.
- The register file is local flops.

## Test plan
- Store 0xA5A5A5A5 with mask 4'b1111 to addr 3, then load addr 3:
  - first response is credit with the correct reg_id;
  - second is int_wb with data 0xA5A5A5A5.
- Store 0x000000FF with mask 4'b0001 over 0x12345678, then load: data is 0x123456FF.
- amoadd 1 to a register holding 0xFFFFFFFF: response data is 0xFFFFFFFF, and a following load returns 0x00000000.
- Store 0x0000BEEF to addr els_p:
  - stat_v_o is high for exactly one cycle with tag 0x0000BEEF;
  - a credit response is returned;
  - error_o stays 0.
- Load at addr els_p+5: response is int_wb with data 0, and error_o=1 persists until reset.
- Hold resp_ready_i=0 and issue 3 loads with fifo_els_p=2:
  - req_ready_o drops after 2 accepts;
  - releasing resp_ready_i drains the responses in order and resumes acceptance;
  - asserting reset_i mid-drain makes resp_v_o=0 in the next cycle.
